// File: rtl/l2_pkg.sv
// Shared types, widths and the deterministic line-fill pattern for the L2 responder.
`timescale 1ns/1ps
package l2_pkg;

  localparam int ADDR_W         = 26;
  localparam int LINE_W         = 512;
  localparam int WORDS_PER_LINE = 16;
  localparam int WORD_W         = LINE_W / WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    SRC_I,
    SRC_D
  } src_e;

  // Each 32-bit word carries its own byte address, so a fill is self-describing.
  function automatic logic [LINE_W-1:0] line_pattern(input logic [ADDR_W-1:0] add);
    logic [LINE_W-1:0] line;
    line = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      line[k*WORD_W +: WORD_W] = {add, 4'(k), 2'b00};
    end
    return line;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
`timescale 1ns/1ps
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_responder.sv
// Single-engine L2 responder: round-robin accepts one I/D line request at a time and
// answers after a fixed latency with a patterned fill or a writeback acknowledge.
`timescale 1ns/1ps
module l2_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = l2_pkg::ADDR_W,
  parameter int LINE_W  = l2_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_add,
  output logic              i_req_ready,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_add,
  input  logic              d_req_write,
  output logic              d_req_ready,
  output logic              i_rsp_valid,
  output logic [ADDR_W-1:0] i_rsp_add,
  output logic [LINE_W-1:0] i_rsp_data,
  output logic              d_rsp_valid,
  output logic [ADDR_W-1:0] d_rsp_add,
  output logic [LINE_W-1:0] d_rsp_data,
  output logic              d_rsp_write,
  output logic              busy,
  output logic [31:0]       i_fill_cnt,
  output logic [31:0]       d_fill_cnt,
  output logic [31:0]       wb_cnt
);

  import l2_pkg::*;

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("l2_responder: LATENCY must be within 1..15");
  end

  if ((ADDR_W != l2_pkg::ADDR_W) || (LINE_W != l2_pkg::LINE_W)) begin : g_bad_width
    $error("l2_responder: ADDR_W/LINE_W must match the fill pattern in l2_pkg");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  state_e            state;
  state_e            state_nx;
  src_e              last_grant;
  src_e              src_q;
  logic [ADDR_W-1:0] add_q;
  logic              write_q;
  logic [3:0]        cnt_q;

  logic              grant_i;
  logic              grant_d;
  logic              accept_i;
  logic              accept_d;
  logic              rsp_fire;
  logic [LINE_W-1:0] fill_line;

  // Ready is withheld during clear so nothing is accepted while resetting.
  always_comb begin
    grant_d     = d_req_valid & (~i_req_valid | (last_grant == SRC_I));
    grant_i     = i_req_valid & ~grant_d;
    i_req_ready = (state == IDLE) & ~clear & grant_i;
    d_req_ready = (state == IDLE) & ~clear & grant_d;
    accept_i    = i_req_valid & i_req_ready;
    accept_d    = d_req_valid & d_req_ready;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept_i || accept_d) begin
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      last_grant <= SRC_I;
      src_q      <= SRC_I;
      add_q      <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state <= state_nx;
      if (accept_i || accept_d) begin
        add_q      <= accept_d ? d_req_add : i_req_add;
        src_q      <= accept_d ? SRC_D : SRC_I;
        last_grant <= accept_d ? SRC_D : SRC_I;
        write_q    <= accept_d & d_req_write;
        cnt_q      <= WAIT_LOAD;
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Response buses stay zero outside their one-cycle pulse.
  always_comb begin
    fill_line   = line_pattern(add_q);
    rsp_fire    = (state == RESP) & ~clear;
    i_rsp_valid = rsp_fire & (src_q == SRC_I);
    d_rsp_valid = rsp_fire & (src_q == SRC_D);
    i_rsp_add   = i_rsp_valid ? add_q : '0;
    i_rsp_data  = i_rsp_valid ? fill_line : '0;
    d_rsp_add   = d_rsp_valid ? add_q : '0;
    d_rsp_write = d_rsp_valid & write_q;
    d_rsp_data  = (d_rsp_valid && !write_q) ? fill_line : '0;
    busy        = (state != IDLE);
  end

  sat_counter #(.WIDTH(32)) u_i_fill_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (accept_i),
    .count (i_fill_cnt)
  );

  sat_counter #(.WIDTH(32)) u_d_fill_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (accept_d & ~d_req_write),
    .count (d_fill_cnt)
  );

  sat_counter #(.WIDTH(32)) u_wb_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (accept_d & d_req_write),
    .count (wb_cnt)
  );

endmodule

// File: tb/tb_l2_responder.sv
// Scoreboard bench for l2_responder: instance 0 runs LATENCY=4, instance 1 runs LATENCY=1.
`timescale 1ns/1ps
module tb_l2_responder;

  localparam int AW   = 26;
  localparam int LW   = 512;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic          clk;
  logic          clear;
  int            cyc;
  int            checks;
  int            errors;

  logic          i_req_valid [2];
  logic [AW-1:0] i_req_add   [2];
  logic          i_req_ready [2];
  logic          d_req_valid [2];
  logic [AW-1:0] d_req_add   [2];
  logic          d_req_write [2];
  logic          d_req_ready [2];
  logic          i_rsp_valid [2];
  logic [AW-1:0] i_rsp_add   [2];
  logic [LW-1:0] i_rsp_data  [2];
  logic          d_rsp_valid [2];
  logic [AW-1:0] d_rsp_add   [2];
  logic [LW-1:0] d_rsp_data  [2];
  logic          d_rsp_write [2];
  logic          busy        [2];
  logic [31:0]   i_fill_cnt  [2];
  logic [31:0]   d_fill_cnt  [2];
  logic [31:0]   wb_cnt      [2];

  typedef struct {
    int            inst;
    bit            is_d;
    logic [AW-1:0] add;
    bit            wr;
    int            due;
  } exp_t;

  exp_t sb[$];

  l2_responder #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .clear(clear),
    .i_req_valid(i_req_valid[0]), .i_req_add(i_req_add[0]), .i_req_ready(i_req_ready[0]),
    .d_req_valid(d_req_valid[0]), .d_req_add(d_req_add[0]), .d_req_write(d_req_write[0]),
    .d_req_ready(d_req_ready[0]),
    .i_rsp_valid(i_rsp_valid[0]), .i_rsp_add(i_rsp_add[0]), .i_rsp_data(i_rsp_data[0]),
    .d_rsp_valid(d_rsp_valid[0]), .d_rsp_add(d_rsp_add[0]), .d_rsp_data(d_rsp_data[0]),
    .d_rsp_write(d_rsp_write[0]), .busy(busy[0]),
    .i_fill_cnt(i_fill_cnt[0]), .d_fill_cnt(d_fill_cnt[0]), .wb_cnt(wb_cnt[0])
  );

  l2_responder #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .clear(clear),
    .i_req_valid(i_req_valid[1]), .i_req_add(i_req_add[1]), .i_req_ready(i_req_ready[1]),
    .d_req_valid(d_req_valid[1]), .d_req_add(d_req_add[1]), .d_req_write(d_req_write[1]),
    .d_req_ready(d_req_ready[1]),
    .i_rsp_valid(i_rsp_valid[1]), .i_rsp_add(i_rsp_add[1]), .i_rsp_data(i_rsp_data[1]),
    .d_rsp_valid(d_rsp_valid[1]), .d_rsp_add(d_rsp_add[1]), .d_rsp_data(d_rsp_data[1]),
    .d_rsp_write(d_rsp_write[1]), .busy(busy[1]),
    .i_fill_cnt(i_fill_cnt[1]), .d_fill_cnt(d_fill_cnt[1]), .wb_cnt(wb_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [LW-1:0] expLine(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    logic [3:0]    k4;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      k4 = k[3:0];
      r[32*k +: 32] = {a, k4, 2'b00};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int u, input bit iv, input logic [AW-1:0] ia,
                               input bit dv, input logic [AW-1:0] da, input bit dw);
    i_req_valid[u] = iv;
    i_req_add[u]   = ia;
    d_req_valid[u] = dv;
    d_req_add[u]   = da;
    d_req_write[u] = dw;
  endtask

  // Waits for the expected side's ready, checks how many cycles it took, and
  // schedules the response on the scoreboard using the bench's own timing.
  task automatic waitAccept(input int u, input bit is_d, input logic [AW-1:0] add, input bit wr,
                            input int exp_gap, input bit push);
    int   start;
    int   n;
    bit   seen;
    logic rdy;
    start = 0;
    n     = 0;
    seen  = 1'b0;
    for (int t = 0; t <= 24 && !seen; t++) begin
      @(negedge clk);
      if (t == 0) start = cyc;
      rdy = is_d ? d_req_ready[u] : i_req_ready[u];
      if (rdy) begin
        seen = 1'b1;
        n    = t;
      end
    end
    checkOutput("accept_seen", 512'(seen), 512'(1));
    checkOutput("accept_gap", 512'(n), 512'(exp_gap));
    checkOutput("other_ready", 512'(is_d ? i_req_ready[u] : d_req_ready[u]), 512'(0));
    if (push) sb.push_back('{u, is_d, add, wr, start + exp_gap + latOf(u)});
    nextCycle();
  endtask

  // Monitor: pops the scoreboard on every response pulse; idle buses must read zero.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (i_rsp_valid[u]) begin
        if (sb.size() == 0) begin
          checkOutput("i_rsp_unexpected", 512'(i_rsp_add[u]), 512'(0));
          checkOutput("i_rsp_unexpected_pulse", 512'(1), 512'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("i_rsp_inst", 512'(u), 512'(e.inst));
          checkOutput("i_rsp_side", 512'(0), 512'(e.is_d));
          checkOutput("i_rsp_cycle", 512'(cyc), 512'(e.due));
          checkOutput("i_rsp_add", 512'(i_rsp_add[u]), 512'(e.add));
          checkOutput("i_rsp_data", i_rsp_data[u], expLine(e.add));
        end
      end else begin
        checkOutput("i_rsp_idle", 512'(i_rsp_add[u]) | i_rsp_data[u], 512'(0));
      end
      if (d_rsp_valid[u]) begin
        if (sb.size() == 0) begin
          checkOutput("d_rsp_unexpected_pulse", 512'(1), 512'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("d_rsp_inst", 512'(u), 512'(e.inst));
          checkOutput("d_rsp_side", 512'(1), 512'(e.is_d));
          checkOutput("d_rsp_cycle", 512'(cyc), 512'(e.due));
          checkOutput("d_rsp_add", 512'(d_rsp_add[u]), 512'(e.add));
          checkOutput("d_rsp_write", 512'(d_rsp_write[u]), 512'(e.wr));
          checkOutput("d_rsp_data", d_rsp_data[u], e.wr ? 512'(0) : expLine(e.add));
        end
      end else begin
        checkOutput("d_rsp_idle", 512'(d_rsp_add[u]) | d_rsp_data[u] | 512'(d_rsp_write[u]), 512'(0));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    for (int u = 0; u < 2; u++) applyStimulus(u, 0, '0, 0, '0, 0);
    repeat (3) nextCycle();

    // Reset state; a request presented during clear must not be accepted.
    applyStimulus(0, 1, 26'h0000123, 0, '0, 0);
    @(negedge clk);
    checkOutput("ready_in_clear", 512'(i_req_ready[0]), 512'(0));
    checkOutput("reset_busy", 512'(busy[0]), 512'(0));
    checkOutput("reset_cnts", 512'({i_fill_cnt[0], d_fill_cnt[0], wb_cnt[0]}), 512'(0));
    nextCycle();
    clear = 1'b0;

    // I fill at 0x123 with hand-computed words.
    waitAccept(0, 0, 26'h0000123, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("s1_valid", 512'(i_rsp_valid[0]), 512'(1));
    checkOutput("s1_word0", 512'(i_rsp_data[0][31:0]), 512'(32'h0000_48C0));
    checkOutput("s1_word15", 512'(i_rsp_data[0][511:480]), 512'(32'h0000_48FC));
    nextCycle();
    @(negedge clk);
    checkOutput("s1_i_fill_cnt", 512'(i_fill_cnt[0]), 512'(1));
    checkOutput("s1_busy", 512'(busy[0]), 512'(0));

    // Tie after an I grant: D first, I waits LATENCY cycles.
    nextCycle();
    applyStimulus(0, 1, 26'h1, 1, 26'h2, 0);
    waitAccept(0, 1, 26'h2, 0, 0, 1);
    applyStimulus(0, 1, 26'h1, 0, '0, 0);
    waitAccept(0, 0, 26'h1, 0, LAT0, 1);
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (LAT0) nextCycle();
    @(negedge clk);
    checkOutput("s2_i_fill_cnt", 512'(i_fill_cnt[0]), 512'(2));
    checkOutput("s2_d_fill_cnt", 512'(d_fill_cnt[0]), 512'(1));

    // D writeback at the top line address.
    nextCycle();
    applyStimulus(0, 0, '0, 1, 26'h3FFFFFF, 1);
    waitAccept(0, 1, 26'h3FFFFFF, 1, 0, 1);
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (LAT0) nextCycle();
    @(negedge clk);
    checkOutput("s3_wb_cnt", 512'(wb_cnt[0]), 512'(1));
    checkOutput("s3_d_fill_cnt", 512'(d_fill_cnt[0]), 512'(1));

    // Clear restores last_grant to I and zeroes counters.
    nextCycle();
    clear = 1'b1;
    nextCycle();
    clear = 1'b0;
    @(negedge clk);
    checkOutput("clr_cnts", 512'({i_fill_cnt[0], d_fill_cnt[0], wb_cnt[0]}), 512'(0));

    // Both sides held valid for six transactions: D,I,D,I,D,I.
    nextCycle();
    applyStimulus(0, 1, 26'h10, 1, 26'h20, 0);
    for (int k = 0; k < 6; k++) begin
      bit            side_d;
      logic [AW-1:0] a;
      side_d = (k % 2) == 0;
      a      = side_d ? (26'h20 + 26'(k / 2)) : (26'h10 + 26'(k / 2));
      waitAccept(0, side_d, a, 0, (k == 0) ? 0 : LAT0, 1);
      if (side_d) d_req_add[0] = a + 26'h1;
      else        i_req_add[0] = a + 26'h1;
    end
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (LAT0) nextCycle();
    @(negedge clk);
    checkOutput("s4_i_fill_cnt", 512'(i_fill_cnt[0]), 512'(3));
    checkOutput("s4_d_fill_cnt", 512'(d_fill_cnt[0]), 512'(3));

    // Clear two cycles after an accept drops the request; D accepted right after.
    nextCycle();
    applyStimulus(0, 1, 26'h55, 0, '0, 0);
    waitAccept(0, 0, 26'h55, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, '0, 0);
    nextCycle();
    clear = 1'b1;
    applyStimulus(0, 0, '0, 1, 26'h77, 0);
    @(negedge clk);
    checkOutput("s5_ready_in_clear", 512'(d_req_ready[0]), 512'(0));
    nextCycle();
    clear = 1'b0;
    waitAccept(0, 1, 26'h77, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (LAT0) nextCycle();
    @(negedge clk);
    checkOutput("s5_i_fill_cnt", 512'(i_fill_cnt[0]), 512'(0));
    checkOutput("s5_d_fill_cnt", 512'(d_fill_cnt[0]), 512'(1));

    // LATENCY=1: response at T+1, next accept at T+2.
    nextCycle();
    applyStimulus(1, 1, 26'h9, 0, '0, 0);
    waitAccept(1, 0, 26'h9, 0, 0, 1);
    i_req_add[1] = 26'hA;
    waitAccept(1, 0, 26'hA, 0, LAT1, 1);
    applyStimulus(1, 0, '0, 0, '0, 0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("s6_i_fill_cnt", 512'(i_fill_cnt[1]), 512'(2));

    repeat (3) nextCycle();
    checkOutput("sb_drain", 512'(sb.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
